// File: rtl/md_pkg.sv
// Shared definitions for the execute-stage multiply/divide unit: op encodings,
// default latencies and the control state type.
package md_pkg;

  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } md_state_e;

endpackage

// File: rtl/mdu_result.sv
// Combinational {hi,lo} result for MULT/MULTU/DIV/DIVU plus a divide-by-zero flag.
module mdu_result
  import md_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] result,
  output logic        div_zero
);

  logic signed [63:0] a_sx, b_sx, prod_s;
  logic        [63:0] prod_u;
  logic signed [31:0] a_s, b_s, quot_s, rem_s;
  logic        [31:0] b_safe, quot_u, rem_u;
  logic               b_zero, s_ovf;

  // Zero divisor and INT_MIN/-1 are resolved without dividing, so the divider
  // never sees an operand pair with an undefined result.
  assign b_zero = (b == 32'd0);
  assign s_ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
  assign b_safe = (b_zero || s_ovf) ? 32'd1 : b;

  assign a_sx   = {{32{a[31]}}, a};
  assign b_sx   = {{32{b[31]}}, b};
  assign prod_s = a_sx * b_sx;
  assign prod_u = {32'd0, a} * {32'd0, b};

  assign a_s    = a;
  assign b_s    = b_safe;
  assign quot_s = a_s / b_s;
  assign rem_s  = a_s % b_s;
  assign quot_u = a / b_safe;
  assign rem_u  = a % b_safe;

  always_comb begin
    result   = 64'd0;
    div_zero = 1'b0;
    case (op)
      MD_MULT:  result = prod_s;
      MD_MULTU: result = prod_u;
      MD_DIV: begin
        div_zero = b_zero;
        if (s_ovf) result = {32'd0, 32'h8000_0000};
        else       result = {rem_s, quot_s};
      end
      MD_DIVU: begin
        div_zero = b_zero;
        result   = {rem_u, quot_u};
      end
      default: result = 64'd0;
    endcase
  end

endmodule

// File: rtl/stage_e_mdu.sv
// Execute-stage MDU: owns HI/LO, runs multi-cycle MULT/DIV on a down-counter
// and commits the latched result atomically when the counter expires.
module stage_e_mdu
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic [2:0]  Op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        IntReq,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  md_state_e          state, state_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic [63:0]        pend, pend_d;
  logic               pend_dz, pend_dz_d;
  logic [31:0]        hi_d, lo_d;
  logic [63:0]        res;
  logic               res_dz;
  logic               accept;

  mdu_result u_result (
    .op       (Op),
    .a        (A),
    .b        (B),
    .result   (res),
    .div_zero (res_dz)
  );

  assign Busy   = (state == RUN);
  assign accept = Start && !Busy && !IntReq;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state   <= IDLE;
      cnt     <= '0;
      pend    <= 64'd0;
      pend_dz <= 1'b0;
      HI      <= 32'd0;
      LO      <= 32'd0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      pend    <= pend_d;
      pend_dz <= pend_dz_d;
      HI      <= hi_d;
      LO      <= lo_d;
    end
  end

  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    pend_d    = pend;
    pend_dz_d = pend_dz;
    hi_d      = HI;
    lo_d      = LO;
    unique case (state)
      IDLE: begin
        if (accept) begin
          case (Op)
            MD_MTHI: hi_d = A;
            MD_MTLO: lo_d = A;
            MD_MULT, MD_MULTU: begin
              pend_d    = res;
              pend_dz_d = 1'b0;
              cnt_d     = CNT_W'(MULT_CYCLES);
              state_d   = RUN;
            end
            MD_DIV, MD_DIVU: begin
              pend_d    = res;
              pend_dz_d = res_dz;
              cnt_d     = CNT_W'(DIV_CYCLES);
              state_d   = RUN;
            end
            default: ;
          endcase
        end
      end
      RUN: begin
        // A divide by zero still burns its full latency but leaves HI/LO untouched.
        if (cnt == CNT_W'(1)) begin
          state_d = IDLE;
          cnt_d   = '0;
          if (!pend_dz) begin
            hi_d = pend[63:32];
            lo_d = pend[31:0];
          end
        end else begin
          cnt_d = cnt - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_stage_e_mdu.sv
// Directed bench for stage_e_mdu: latency, arithmetic results, flush/busy
// interaction, back-to-back issue and asynchronous reset.
module tb_stage_e_mdu;
  import md_pkg::*;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Start;
  logic [2:0]  Op;
  logic [31:0] A, B;
  logic        IntReq;
  logic        Busy;
  logic [31:0] HI, LO;

  int n_chk  = 0;
  int n_pass = 0;
  int nbusy;

  stage_e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .Clk    (Clk),
    .Reset  (Reset),
    .Start  (Start),
    .Op     (Op),
    .A      (A),
    .B      (B),
    .IntReq (IntReq),
    .Busy   (Busy),
    .HI     (HI),
    .LO     (LO)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // Drive one Start in the current cycle; returns #1 after the sampling edge.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic irq);
    @(negedge Clk);
    Start = 1'b1; Op = op; A = a; B = b; IntReq = irq;
    @(posedge Clk); #1;
    Start = 1'b0; IntReq = 1'b0; Op = 3'd7; A = 32'd0; B = 32'd0;
  endtask

  // Count cycles Busy stays high, bounded so a stuck Busy cannot hang the run.
  task automatic count_busy(output int n);
    n = 0;
    while (Busy && n < 50) begin
      n++;
      @(posedge Clk); #1;
    end
  endtask

  initial begin
    Reset = 1'b1; Start = 1'b0; Op = 3'd7; A = 32'd0; B = 32'd0; IntReq = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    check("rst_busy", {31'd0, Busy}, 32'd0);
    check("rst_hi", HI, 32'd0);
    check("rst_lo", LO, 32'd0);
    @(negedge Clk); Reset = 1'b0;

    // MULT -2 * 3
    issue(MD_MULT, 32'hFFFF_FFFE, 32'd3, 1'b0);
    count_busy(nbusy);
    check("mult_busy_cycles", nbusy, 32'd5);
    check("mult_hi", HI, 32'hFFFF_FFFF);
    check("mult_lo", LO, 32'hFFFF_FFFA);

    // MULTU max * max
    issue(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    count_busy(nbusy);
    check("multu_busy_cycles", nbusy, 32'd5);
    check("multu_hi", HI, 32'hFFFF_FFFE);
    check("multu_lo", LO, 32'h0000_0001);

    // DIV -7 / 2
    issue(MD_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
    count_busy(nbusy);
    check("div_busy_cycles", nbusy, 32'd10);
    check("div_lo", LO, 32'hFFFF_FFFD);
    check("div_hi", HI, 32'hFFFF_FFFF);

    // DIVU by zero keeps HI/LO
    issue(MD_DIVU, 32'd1234, 32'd0, 1'b0);
    count_busy(nbusy);
    check("divz_busy_cycles", nbusy, 32'd10);
    check("divz_hi", HI, 32'hFFFF_FFFF);
    check("divz_lo", LO, 32'hFFFF_FFFD);

    // Signed overflow INT_MIN / -1
    issue(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    count_busy(nbusy);
    check("ovf_lo", LO, 32'h8000_0000);
    check("ovf_hi", HI, 32'h0000_0000);

    // MULT flushed by IntReq
    issue(MD_MULT, 32'd5, 32'd7, 1'b1);
    check("irq_busy", {31'd0, Busy}, 32'd0);
    repeat (6) @(posedge Clk);
    #1;
    check("irq_hi", HI, 32'h0000_0000);
    check("irq_lo", LO, 32'h8000_0000);

    // MTLO: visible next cycle, never busy
    issue(MD_MTLO, 32'hCAFE_BABE, 32'd0, 1'b0);
    check("mtlo_lo", LO, 32'hCAFE_BABE);
    check("mtlo_busy", {31'd0, Busy}, 32'd0);
    check("mtlo_hi", HI, 32'h0000_0000);

    // Unknown op code is a no-op
    issue(3'd7, 32'h5555_5555, 32'd9, 1'b0);
    check("badop_busy", {31'd0, Busy}, 32'd0);
    check("badop_lo", LO, 32'hCAFE_BABE);

    // MTHI while busy is ignored; DIV issued the cycle Busy falls
    issue(MD_MULT, 32'h0001_0000, 32'h0003_0000, 1'b0);
    check("mult2_busy", {31'd0, Busy}, 32'd1);
    issue(MD_MTHI, 32'h0000_1234, 32'd0, 1'b0);
    check("mthi_busy_hi", HI, 32'h0000_0000);
    count_busy(nbusy);
    check("mult2_busy_rest", nbusy, 32'd4);
    check("mult2_hi", HI, 32'h0000_0003);
    check("mult2_lo", LO, 32'h0000_0000);
    issue(MD_DIV, 32'd100, 32'd7, 1'b0);
    count_busy(nbusy);
    check("b2b_div_busy", nbusy, 32'd10);
    check("b2b_div_lo", LO, 32'd14);
    check("b2b_div_hi", HI, 32'd2);

    // Reset during cycle 3 of a DIV
    issue(MD_DIV, 32'd50, 32'd3, 1'b0);
    @(posedge Clk); @(posedge Clk); #1;
    Reset = 1'b1;
    #1;
    check("midrst_busy", {31'd0, Busy}, 32'd0);
    check("midrst_hi", HI, 32'd0);
    check("midrst_lo", LO, 32'd0);
    @(negedge Clk); Reset = 1'b0;
    repeat (15) @(posedge Clk);
    #1;
    check("postrst_busy", {31'd0, Busy}, 32'd0);
    check("postrst_hi", HI, 32'd0);
    check("postrst_lo", LO, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
